// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the ID/EX stage and the execute ALU.
// The master drives operations and consumes results; the slave is the ALU.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctr;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, alu_ctr, src_a, src_b, shamt, out_ready,
        input  in_ready, out_valid, result, zero, overflow, illegal
    );

    modport slave (
        input  in_valid, alu_ctr, src_a, src_b, shamt, out_ready,
        output in_ready, out_valid, result, zero, overflow, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Handshaked execute-stage ALU: single-cycle logic/arithmetic ops, and
// shifts that walk one bit per cycle so the pipeline stalls on in_ready.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input logic            clk,
    input logic            rst_n,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] work_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             overflow_q;
    logic             illegal_q;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] diff_d;
    logic [WIDTH-1:0] alu_res_d;
    logic             alu_ovf_d;
    logic             alu_ill_d;
    logic             is_shift_d;
    logic [WIDTH-1:0] sll_step_d;
    logic [WIDTH-1:0] srx_step_d;
    logic [WIDTH-1:0] shift_step_d;
    logic             sra_fill_d;

    assign sum_d  = bus.src_a + bus.src_b;
    assign diff_d = bus.src_a - bus.src_b;

    // Single-cycle datapath, evaluated on the live inputs and captured at accept.
    always_comb begin
        alu_res_d  = '0;
        alu_ovf_d  = 1'b0;
        alu_ill_d  = 1'b0;
        is_shift_d = 1'b0;
        case (bus.alu_ctr)
            OP_AND: alu_res_d = bus.src_a & bus.src_b;
            OP_OR:  alu_res_d = bus.src_a | bus.src_b;
            OP_NOR: alu_res_d = ~(bus.src_a | bus.src_b);
            OP_ADD: begin
                alu_res_d = sum_d;
                alu_ovf_d = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &&
                            (sum_d[WIDTH-1] != bus.src_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_d = diff_d;
                alu_ovf_d = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &&
                            (diff_d[WIDTH-1] != bus.src_a[WIDTH-1]);
            end
            // Direct signed compare, so a wrapped A-B never flips the answer.
            OP_SLT: alu_res_d = {{(WIDTH-1){1'b0}},
                                 ($signed(bus.src_a) < $signed(bus.src_b))};
            OP_SLL, OP_SRL, OP_SRA: begin
                alu_res_d  = bus.src_a;
                is_shift_d = 1'b1;
            end
            default: alu_ill_d = 1'b1;
        endcase
    end

    assign sra_fill_d = (op_q == OP_SRA) ? work_q[WIDTH-1] : 1'b0;

    // One-bit shift network applied to the working register each SHIFT cycle.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == 0) begin : g_sll_lsb
                assign sll_step_d[gi] = 1'b0;
            end else begin : g_sll_bit
                assign sll_step_d[gi] = work_q[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_srx_msb
                assign srx_step_d[gi] = sra_fill_d;
            end else begin : g_srx_bit
                assign srx_step_d[gi] = work_q[gi+1];
            end
        end
    endgenerate

    assign shift_step_d = (op_q == OP_SLL) ? sll_step_d : srx_step_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q   <= bus.alu_ctr;
                        work_q <= bus.src_a;
                        cnt_q  <= bus.shamt;
                        if (is_shift_d && (bus.shamt != '0)) begin
                            state_q <= SHIFT;
                        end else begin
                            state_q    <= DONE;
                            result_q   <= alu_res_d;
                            zero_q     <= (alu_res_d == '0);
                            overflow_q <= alu_ovf_d;
                            illegal_q  <= alu_ill_d;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= shift_step_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == 1) begin
                        state_q    <= DONE;
                        result_q   <= shift_step_d;
                        zero_q     <= (shift_step_d == '0);
                        overflow_q <= 1'b0;
                        illegal_q  <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.illegal   = illegal_q;
endmodule
